// File: rtl/soc_simple_mem_pkg.sv
// Shared types and helpers for the two-master on-chip memory arbiter.
package soc_simple_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   localparam int unsigned DEPTH_DEF = 1024;
   localparam int unsigned AW_DEF    = 10;

   // 33-bit compare so a window ending at 4 GiB cannot wrap to zero
   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned depth);
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + ({1'b0, 32'(depth)} << 2);
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/soc_simple_mem_arbiter_if.sv
// Fetch master, data master and memory port bundled for the arbiter.
interface soc_simple_mem_arbiter_if #(parameter int unsigned AW = 10);

   logic [31:0]   i_address;
   logic          i_read;
   logic          i_waitrequest;
   logic [31:0]   i_readdata;
   logic          i_readdatavalid;

   logic [31:0]   d_address;
   logic          d_read;
   logic          d_write;
   logic [3:0]    d_byteenable;
   logic [31:0]   d_writedata;
   logic          d_waitrequest;
   logic [31:0]   d_readdata;
   logic          d_readdatavalid;

   logic [AW-1:0] m_address;
   logic [3:0]    m_byteenable;
   logic          m_chipselect;
   logic          m_write;
   logic [31:0]   m_writedata;
   logic          m_clken;
   logic [31:0]   m_readdata;

   modport slave (
      input  i_address, i_read,
      output i_waitrequest, i_readdata, i_readdatavalid,
      input  d_address, d_read, d_write, d_byteenable, d_writedata,
      output d_waitrequest, d_readdata, d_readdatavalid,
      output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
      input  m_readdata
   );

   modport master (
      output i_address, i_read,
      input  i_waitrequest, i_readdata, i_readdatavalid,
      output d_address, d_read, d_write, d_byteenable, d_writedata,
      input  d_waitrequest, d_readdata, d_readdatavalid,
      input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
      output m_readdata
   );

endinterface

// File: rtl/soc_simple_mem_arbiter.sv
// Shares one single-port memory between fetch and data masters: data-first
// priority, bounded fetch starvation, 1-cycle read return, address window filter.
//
// owner_q  | meaning
// OWN_NONE | no read returns this cycle
// OWN_I    | fetch read returns this cycle
// OWN_D    | data read returns this cycle
module soc_simple_mem_arbiter
   import soc_simple_mem_pkg::*;
#(
   parameter int unsigned DEPTH        = DEPTH_DEF,
   parameter int unsigned AW           = AW_DEF,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   soc_simple_mem_arbiter_if.slave   bus,
   output logic                      range_err
);

   logic        d_req;
   logic        i_req;
   logic        d_win;
   logic        i_win;
   logic        sel_ok;
   logic [31:0] sel_addr;
   logic [31:0] rsp_data;

   logic        clken_q;
   logic [3:0]  starve_cnt;
   owner_t      owner_q;
   logic        zero_q;
   logic [31:0] i_hold;
   logic [31:0] d_hold;

   always_comb begin
      d_req    = bus.d_read | bus.d_write;
      i_req    = bus.i_read;
      d_win    = d_req && !(i_req && (starve_cnt == 4'(STARVE_LIMIT)));
      i_win    = i_req && !d_win;
      sel_addr = d_win ? bus.d_address : bus.i_address;
      sel_ok   = in_range(sel_addr, BASE_ADDR, DEPTH);
      rsp_data = zero_q ? 32'h0 : bus.m_readdata;
   end

   assign bus.i_waitrequest   = i_req && !i_win;
   assign bus.d_waitrequest   = d_req && !d_win;

   assign bus.m_address       = AW'((sel_addr - BASE_ADDR) >> 2);
   assign bus.m_byteenable    = d_win ? bus.d_byteenable : 4'hF;
   assign bus.m_writedata     = bus.d_writedata;
   // reset_n gate keeps the memory idle while the arbiter is held in reset
   assign bus.m_chipselect    = reset_n && (d_win || i_win) && sel_ok;
   assign bus.m_write         = reset_n && d_win && bus.d_write && sel_ok;
   assign bus.m_clken         = clken_q;

   assign bus.i_readdatavalid = (owner_q == OWN_I);
   assign bus.d_readdatavalid = (owner_q == OWN_D);
   assign bus.i_readdata      = (owner_q == OWN_I) ? rsp_data : i_hold;
   assign bus.d_readdata      = (owner_q == OWN_D) ? rsp_data : d_hold;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clken_q    <= 1'b0;
         starve_cnt <= 4'd0;
         owner_q    <= OWN_NONE;
         zero_q     <= 1'b0;
         i_hold     <= 32'h0;
         d_hold     <= 32'h0;
         range_err  <= 1'b0;
      end else begin
         clken_q <= 1'b1;

         if (i_req && d_win)
            starve_cnt <= (starve_cnt == 4'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 4'd1;
         else
            starve_cnt <= 4'd0;

         // read+write together counts as a write, so only a pure read claims the return slot
         if (i_win)
            owner_q <= OWN_I;
         else if (d_win && !bus.d_write)
            owner_q <= OWN_D;
         else
            owner_q <= OWN_NONE;
         zero_q <= !sel_ok;

         if (owner_q == OWN_I)
            i_hold <= rsp_data;
         if (owner_q == OWN_D)
            d_hold <= rsp_data;

         if ((d_win || i_win) && !sel_ok)
            range_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_soc_simple_mem_arbiter.sv
// Directed bench for soc_simple_mem_arbiter with a transaction-level reference
// model checked every cycle, plus literal spot checks of known memory contents.
module tb_soc_simple_mem_arbiter;

   localparam int unsigned DEPTH  = 1024;
   localparam int unsigned AW     = 10;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam int unsigned LIMIT  = 4;

   logic clk = 1'b0;
   logic reset_n;
   logic range_err;

   int checks   = 0;
   int failures = 0;

   soc_simple_mem_arbiter_if #(.AW(AW)) bus();

   soc_simple_mem_arbiter #(
      .DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .range_err(range_err)
   );

   always #5 clk = ~clk;

   // memory behind the arbiter: registered address, unregistered q
   logic [31:0] sram [DEPTH];
   logic [AW-1:0] sram_a = '0;
   always @(posedge clk) begin
      if (bus.m_clken && bus.m_chipselect) begin
         if (bus.m_write)
            for (int b = 0; b < 4; b++)
               if (bus.m_byteenable[b]) sram[bus.m_address][8*b +: 8] <= bus.m_writedata[8*b +: 8];
         sram_a <= bus.m_address;
      end
   end
   assign bus.m_readdata = sram[sram_a];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model state
   logic [31:0] ref_mem [DEPTH];
   int          p_own   = 0;
   logic [31:0] p_data  = '0;
   logic [31:0] h_i     = '0;
   logic [31:0] h_d     = '0;
   int unsigned losses  = 0;
   logic        rerr    = 1'b0;
   logic        run     = 1'b0;

   always @(negedge clk) begin
      logic dq, iq, dw, iw, ok;
      longint unsigned a;
      int unsigned idx;
      if (!reset_n) begin
         chk("rst_i_dv", 32'(bus.i_readdatavalid), 32'd0);
         chk("rst_d_dv", 32'(bus.d_readdatavalid), 32'd0);
         chk("rst_clken", 32'(bus.m_clken), 32'd0);
         chk("rst_cs", 32'(bus.m_chipselect), 32'd0);
         chk("rst_wr", 32'(bus.m_write), 32'd0);
         chk("rst_rerr", 32'(range_err), 32'd0);
         p_own = 0; h_i = '0; h_d = '0; losses = 0; rerr = 1'b0; run = 1'b0;
      end else begin
         chk("clken", 32'(bus.m_clken), 32'(run));
         chk("i_dv", 32'(bus.i_readdatavalid), 32'(p_own == 1));
         chk("d_dv", 32'(bus.d_readdatavalid), 32'(p_own == 2));
         if (p_own == 1) h_i = p_data;
         if (p_own == 2) h_d = p_data;
         chk("i_rdata", bus.i_readdata, h_i);
         chk("d_rdata", bus.d_readdata, h_d);
         chk("range_err", 32'(range_err), 32'(rerr));

         dq = bus.d_read | bus.d_write;
         iq = bus.i_read;
         dw = dq && !(iq && losses >= LIMIT);
         iw = iq && !dw;
         chk("i_wait", 32'(bus.i_waitrequest), 32'(iq && !iw));
         chk("d_wait", 32'(bus.d_waitrequest), 32'(dq && !dw));

         a   = dw ? longint'(bus.d_address) : longint'(bus.i_address);
         ok  = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * longint'(DEPTH));
         idx = int'((a - longint'(BASE)) / 4) % DEPTH;
         chk("m_cs", 32'(bus.m_chipselect), 32'((dw || iw) && ok));
         chk("m_wr", 32'(bus.m_write), 32'(dw && bus.d_write && ok));
         if ((dw || iw) && ok) begin
            chk("m_addr", 32'(bus.m_address), 32'(idx));
            chk("m_be", 32'(bus.m_byteenable), dw ? 32'(bus.d_byteenable) : 32'hF);
            if (dw && bus.d_write) chk("m_wdata", bus.m_writedata, bus.d_writedata);
         end

         if ((dw || iw) && !ok) rerr = 1'b1;
         p_own  = iw ? 1 : (dw && !bus.d_write) ? 2 : 0;
         p_data = ok ? ref_mem[idx] : 32'h0;
         if (dw && bus.d_write && ok)
            for (int b = 0; b < 4; b++)
               if (bus.d_byteenable[b]) ref_mem[idx][8*b +: 8] = bus.d_writedata[8*b +: 8];
         losses = (iq && dw) ? ((losses + 1 > LIMIT) ? LIMIT : losses + 1) : 0;
         run    = 1'b1;
      end
   end

   task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dwr,
                       input logic [31:0] da, input logic [3:0] be, input logic [31:0] wd);
      @(posedge clk);
      #1;
      bus.i_read = ir;   bus.i_address = ia;
      bus.d_read = dr;   bus.d_write = dwr;  bus.d_address = da;
      bus.d_byteenable = be; bus.d_writedata = wd;
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   logic [9:0]  pat;
   logic [31:0] mx_addr [6] = '{32'h100, 32'h104, 32'hFFFF_FFFC, 32'h100, 32'h104, 32'h108};
   logic        mx_wr   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [3:0]  mx_be   [6] = '{4'b1100, 4'b0101, 4'hF, 4'hF, 4'hF, 4'b1000};

   initial begin
      for (int k = 0; k < DEPTH; k++) begin
         sram[k]    = 32'(k) * 32'h9E37_79B1 + 32'd1;
         ref_mem[k] = 32'(k) * 32'h9E37_79B1 + 32'd1;
      end
      reset_n = 1'b0;
      bus.i_read = 1'b0; bus.i_address = '0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0;
      bus.d_byteenable = '0; bus.d_writedata = '0;
      settle();
      settle();
      chk("lit_reset_clken", 32'(bus.m_clken), 32'd0);
      @(posedge clk); #1; reset_n = 1'b1;
      settle();
      chk("lit_clken_before_edge", 32'(bus.m_clken), 32'd0);
      settle();
      chk("lit_clken_after_edge", 32'(bus.m_clken), 32'd1);

      // fetch-only burst
      step(1'b1, 32'h000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle(); chk("lit_fetch_wait", 32'(bus.i_waitrequest), 32'd0);
      step(1'b1, 32'h004, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle(); chk("lit_fetch0", bus.i_readdata, 32'h0000_0001);
      step(1'b1, 32'h008, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle(); chk("lit_fetch1", bus.i_readdata, 32'h9E37_79B2);
      idle();
      settle(); chk("lit_fetch2", bus.i_readdata, 32'h3C6E_F363);

      // partial write then read back
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h010, 4'b0011, 32'hDEAD_BEEF);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h010, 4'hF, 32'h0);
      idle();
      settle();
      chk("lit_d_dv", 32'(bus.d_readdatavalid), 32'd1);
      chk("lit_d_merge", bus.d_readdata, 32'h78DD_BEEF);
      chk("lit_i_hold", bus.i_readdata, 32'h3C6E_F363);

      // both masters contend: D,D,D,D,I repeating
      pat = '0;
      for (int c = 0; c < 10; c++) begin
         step(1'b1, 32'h020, 1'b1, 1'b0, 32'h040, 4'hF, 32'h0);
         settle();
         pat = {pat[8:0], bus.i_waitrequest};
      end
      chk("lit_starve_pattern", 32'(pat), 32'(10'b1111011110));
      idle();

      // first out-of-range fetch
      step(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle(); chk("lit_oor_cs", 32'(bus.m_chipselect), 32'd0);
      idle();
      settle();
      chk("lit_oor_dv", 32'(bus.i_readdatavalid), 32'd1);
      chk("lit_oor_data", bus.i_readdata, 32'h0);
      chk("lit_oor_err", 32'(range_err), 32'd1);
      idle();
      settle(); chk("lit_oor_sticky", 32'(range_err), 32'd1);

      // alternating owners, one request per cycle
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) step(1'b1, 32'(4 * k), 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
         else            step(1'b0, 32'h0, 1'b1, 1'b0, 32'(32'h200 + 4 * k), 4'hF, 32'h0);
      end
      idle();

      // reset lands while a data read is in flight
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h020, 4'hF, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      bus.d_read = 1'b0;
      settle();
      chk("lit_rst_d_dv", 32'(bus.d_readdatavalid), 32'd0);
      chk("lit_rst_err", 32'(range_err), 32'd0);
      @(posedge clk); #1; reset_n = 1'b1;
      step(1'b1, 32'h004, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      idle();
      settle(); chk("lit_resume", bus.i_readdata, 32'h9E37_79B2);

      // mixed writes/reads, including an out-of-range write and read+write together
      for (int k = 0; k < 6; k++)
         step(1'b0, 32'h0, !mx_wr[k] || k == 5, mx_wr[k], mx_addr[k], mx_be[k], 32'hC0FF_EE00 + 32'(k));
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h108, 4'hF, 32'h0);
      idle();
      idle();
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
